// File: rtl/wb_commit_buffer.sv
// wb_commit_buffer: writeback source select feeding a 2-entry commit buffer with forwarding
module wb_commit_buffer #(
    parameter int DW       = 8,
    parameter int NSRC     = 4,
    parameter int SELW     = 2,
    parameter int AW       = 3,
    parameter int ZERO_REG = 1,
    parameter int CW       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NSRC*DW-1:0] in_src,
    input  logic [SELW-1:0]    in_sel,
    input  logic [AW-1:0]      in_rd,
    input  logic               in_we,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [DW-1:0]      rf_wdata,
    input  logic               rf_ready,
    input  logic [AW-1:0]      fwd_raddr,
    output logic               fwd_hit,
    output logic [DW-1:0]      fwd_data,
    output logic [CW-1:0]      commit_cnt
);
    logic [1:0]      cnt_q, cnt_d;
    logic            head_q, tail_q;
    logic [AW-1:0]   addr_q [2];
    logic [DW-1:0]   data_q [2];
    logic [CW-1:0]   commit_q, commit_d;
    logic [SELW-1:0] sel_eff;
    logic [DW-1:0]   sel_data;
    logic            push, pop, hit_young, hit_old;

    // Clamp out-of-range selects to the last source; decide push/pop from registered state only.
    always_comb begin
        sel_eff  = (32'(in_sel) >= NSRC) ? SELW'(NSRC - 1) : in_sel;
        sel_data = in_src[32'(sel_eff) * DW +: DW];
        in_ready = (cnt_q < 2'd2) && !rst;
        rf_we    = cnt_q != 2'd0;
        pop      = rf_we && rf_ready;
        push     = in_valid && in_ready && in_we && !(ZERO_REG != 0 && in_rd == '0);
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        commit_d = pop ? commit_q + CW'(1) : commit_q;
    end

    // Head drives the write port; when empty, the slot behind head still holds the last popped entry.
    always_comb begin
        rf_waddr   = addr_q[rf_we ? head_q : ~head_q];
        rf_wdata   = data_q[rf_we ? head_q : ~head_q];
        hit_young  = rf_we && addr_q[~tail_q] == fwd_raddr;
        hit_old    = cnt_q == 2'd2 && addr_q[tail_q] == fwd_raddr;
        fwd_hit    = (hit_young || hit_old) && !(ZERO_REG != 0 && fwd_raddr == '0);
        fwd_data   = !fwd_hit ? '0 : hit_young ? data_q[~tail_q] : data_q[tail_q];
        commit_cnt = commit_q;
    end

    // Buffer storage, pointers and commit counter; reset flushes pending entries uncommitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            commit_q <= '0;
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
        end else begin
            cnt_q    <= cnt_d;
            commit_q <= commit_d;
            if (push) begin
                addr_q[tail_q] <= in_rd;
                data_q[tail_q] <= sel_data;
                tail_q         <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
        end
    end
endmodule

// File: tb/tb_wb_commit_buffer.sv
// tb_wb_commit_buffer: random and directed stimulus against a queue-based reference model
module tb_wb_commit_buffer;
    localparam int NSRC = 4;
    typedef struct packed { logic [2:0] a; logic [7:0] d; } ent_t;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_we = 0, rf_ready = 0;
    logic [31:0] in_src = 0;
    logic [1:0]  in_sel = 0;
    logic [2:0]  in_rd = 0, fwd_raddr = 0;
    logic        in_ready, rf_we, fwd_hit;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata, fwd_data;
    logic [15:0] commit_cnt;

    logic        v3 = 0, we3 = 1, rdy3 = 0;
    logic [23:0] src3 = 24'hC3B2A1;
    logic [1:0]  sel3 = 0;
    logic [2:0]  rd3 = 0, fr3 = 0;
    logic        ir3, rfwe3, hit3;
    logic [2:0]  waddr3;
    logic [7:0]  wdata3, fd3;
    logic [15:0] cc3;

    ent_t        exp_q[$];
    ent_t        last = '0;
    logic        exp_rdy = 0;
    logic [15:0] exp_commit = 0;
    int          total = 0, checks = 0, errors = 0;

    wb_commit_buffer u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_src(in_src),
        .in_sel(in_sel), .in_rd(in_rd), .in_we(in_we), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_ready(rf_ready), .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .commit_cnt(commit_cnt)
    );

    wb_commit_buffer #(.NSRC(3), .SELW(2)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .in_src(src3),
        .in_sel(sel3), .in_rd(rd3), .in_we(we3), .rf_we(rfwe3), .rf_waddr(waddr3),
        .rf_wdata(wdata3), .rf_ready(rdy3), .fwd_raddr(fr3), .fwd_hit(hit3),
        .fwd_data(fd3), .commit_cnt(cc3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] msel(input logic [31:0] s, input logic [1:0] sel);
        int k;
        k = (int'(sel) >= NSRC) ? NSRC - 1 : int'(sel);
        return s[k*8 +: 8];
    endfunction

    // Scoreboard push: a stored accept enqueues the expected write.
    always @(posedge clk)
        if (!rst && in_valid && exp_rdy && in_we && in_rd != 0)
            exp_q.push_back('{a: in_rd, d: msel(in_src, in_sel)});

    // Monitor: compare DUT outputs with the model mid-cycle, then retire the head on commit.
    always @(negedge clk) begin
        ent_t h;
        logic fh;
        logic [7:0] fd;
        if (rst) begin
            chk("in_ready_rst", 32'(in_ready), 0);
            exp_q.delete();
            exp_commit = 0;
            last = '0;
            exp_rdy = 0;
            total = 0;
        end else begin
            exp_rdy = exp_q.size() < 2;
            fh = 0;
            fd = 0;
            foreach (exp_q[i])
                if (exp_q[i].a == fwd_raddr && fwd_raddr != 0) begin
                    fh = 1;
                    fd = exp_q[i].d;
                end
            h = exp_q.size() != 0 ? exp_q[0] : last;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("rf_we", 32'(rf_we), 32'(exp_q.size() != 0));
            chk("rf_waddr", 32'(rf_waddr), 32'(h.a));
            chk("rf_wdata", 32'(rf_wdata), 32'(h.d));
            chk("fwd_hit", 32'(fwd_hit), 32'(fh));
            chk("fwd_data", 32'(fwd_data), 32'(fd));
            chk("commit_cnt", 32'(commit_cnt), 32'(exp_commit));
            if (exp_q.size() != 0 && rf_ready) begin
                last = exp_q.pop_front();
                exp_commit++;
                total++;
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [2:0] rd,
                         input logic we, input logic rdy, input logic [2:0] fa);
        in_valid = v; in_sel = s; in_rd = rd; in_we = we; rf_ready = rdy; fwd_raddr = fa;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        // out-of-range select on the 3-source instance
        v3 = 1; sel3 = 2'd3; rd3 = 3'd2;
        @(posedge clk); #1;
        sel3 = 2'd1; rd3 = 3'd6;
        @(posedge clk); #1;
        v3 = 0; fr3 = 3'd6;
        @(negedge clk);
        chk("u3_oob_data", 32'(wdata3), 32'h0C3);
        chk("u3_addr", 32'(waddr3), 2);
        chk("u3_fwd_hit", 32'(hit3), 1);
        chk("u3_fwd_data", 32'(fd3), 32'h0B2);
        chk("u3_in_ready", 32'(ir3), 0);
        // source select, back to back
        in_src = 32'h44332211;
        for (int s = 0; s < 4; s++) drive(1, 2'(s), 3'd5, 1, 1, 3'd5);
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        // backpressure
        in_src = 32'h0000B2A1;
        drive(1, 0, 3'd1, 1, 0, 3'd1);
        drive(1, 1, 3'd2, 1, 0, 3'd2);
        repeat (3) drive(1, 2, 3'd3, 1, 0, 3'd0);
        repeat (4) drive(0, 0, 0, 0, 1, 0);
        // forwarding, younger wins
        in_src = 32'h00002010;
        drive(1, 0, 3'd3, 1, 0, 3'd3);
        drive(1, 1, 3'd3, 1, 0, 3'd3);
        repeat (2) drive(0, 0, 0, 0, 0, 3'd3);
        repeat (2) drive(0, 0, 0, 0, 0, 3'd4);
        repeat (3) drive(0, 0, 0, 0, 1, 3'd3);
        // discards
        drive(1, 0, 3'd7, 0, 1, 3'd0);
        drive(1, 0, 3'd0, 1, 1, 3'd0);
        repeat (2) drive(0, 0, 0, 0, 1, 3'd0);
        // random traffic
        repeat (600) begin
            in_src = $urandom;
            drive($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), $urandom_range(0, 4) != 0,
                  1'($urandom), 3'($urandom));
        end
        // stream until the commit counter wraps through 0xFFFF
        for (int g = 0; g < 70000 && total <= 65536; g++) begin
            in_src = $urandom;
            drive(1, 2'($urandom), 3'($urandom_range(1, 7)), 1, 1, 3'($urandom));
        end
        chk("wrap_reached", 32'(total > 65536), 1);
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        // reset with two entries pending
        in_src = 32'h0000CCBB;
        drive(1, 0, 3'd4, 1, 0, 3'd4);
        drive(1, 1, 3'd5, 1, 0, 3'd4);
        rst = 1;
        drive(0, 0, 0, 0, 1, 3'd4);
        rst = 0;
        repeat (5) drive(0, 0, 0, 0, 1, 3'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_commit_buffer.md
# wb_commit_buffer

Parametrised writeback commit stage for the 8-bit RISC pipeline. It selects the result from one of NSRC source buses (ALU, data memory, MOV, effective address, ...), registers it together with its destination register, and holds it in a 2-entry commit buffer until the register file accepts the write. The register file can refuse writes when its port is busy. It also forwards the youngest pending value for a queried register back to decode and counts committed writes.

## Interface
Parameters:
- DW, 8, data width of every source and of the write data
- NSRC, 4, number of source buses (2..16)
- SELW, 2, select width; must satisfy 2^SELW >= NSRC
- AW, 3, register address width
- ZERO_REG, 1, when 1 register 0 is hard-wired: writes to it are discarded and never forwarded
- CW, 16, width of the commit counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active high
- in_valid  in  1  upstream has a result this cycle
- in_ready  out  1  buffer can accept a result
- in_src  in  NSRC*DW  flattened source buses; source k occupies bits [k*DW +: DW]
- in_sel  in  SELW  source select
- in_rd  in  AW  destination register
- in_we  in  1  instruction writes a register
- rf_we  out  1  write request to the register file (head entry valid)
- rf_waddr  out  AW  head entry destination
- rf_wdata  out  DW  head entry data
- rf_ready  in  1  register file accepts the write this cycle
- fwd_raddr  in  AW  register queried by decode
- fwd_hit  out  1  a pending write to fwd_raddr is buffered
- fwd_data  out  DW  data of the youngest matching pending write
- commit_cnt  out  CW  number of writes committed since reset

## Operation
- Accept: in_valid && in_ready. The selected data is src[in_sel]. If in_sel >= NSRC, source NSRC-1 is used.
- Discard on accept: if in_we == 0, or if ZERO_REG == 1 and in_rd == 0, the result is consumed and not stored. Count and outputs are unchanged.
- Storage: 2-entry FIFO of {addr, data}, with a registered 2-bit count and head/tail pointers that wrap modulo 2.
- Pop: rf_we && rf_ready. The head advances, count decrements, and commit_cnt increments. commit_cnt wraps from 2^CW-1 to 0.
- rf_we = (count != 0). rf_waddr and rf_wdata come from the head entry. When the buffer is empty they hold the last popped entry's values, or 0 after reset.
- in_ready = (count < 2) && !rst. It depends only on registered state, so there is no combinational path from rf_ready to in_ready.
- Simultaneous push and pop:
  - at count 1, count stays 1 and the new entry becomes head on the next cycle;
  - at count 0, only the push occurs, because rf_we is 0.
- Forwarding is purely combinational over buffered entries only. An entry being accepted in the same cycle is not visible.
  - If both entries match fwd_raddr, the younger (tail-1) entry wins.
  - fwd_hit = 0 when nothing matches, and also when ZERO_REG == 1 and fwd_raddr == 0.
  - fwd_data = 0 when fwd_hit = 0.
- rf_ready is ignored while rf_we = 0.

## Timing
- Reset (rst high at a clock edge): count = 0, pointers = 0, storage = 0, commit_cnt = 0. Hence rf_we = 0, rf_waddr = 0, rf_wdata = 0, fwd_hit = 0, fwd_data = 0, and in_ready = 0 while rst is high.
- Reset mid-operation flushes all pending entries without committing them. in_ready returns to 1 in the first cycle after rst deasserts.
- Latency: a result accepted at edge N appears on rf_we/rf_waddr/rf_wdata during the following cycle (after edge N). With rf_ready held high it commits at edge N+1.
- Throughput: 1 write per cycle when rf_ready is held high.
- When rf_ready is low, the head holds stable. After 2 stored accepts, in_ready drops to 0 until a pop.
- fwd_hit and fwd_data update in the same cycle as fwd_raddr changes, and reflect state after the most recent edge.
- Discarded accepts cost one cycle of in_valid and produce no rf_we.

## Test plan
- Source select with NSRC=4, DW=8, src = {0x44,0x33,0x22,0x11} (src0 = 0x11) and rf_ready=1. Accept sel 0..3 with rd=5 on consecutive cycles -> rf_wdata = 0x11, 0x22, 0x33, 0x44 on consecutive cycles, each 1 cycle after its accept, with rf_waddr=5 and commit_cnt=4.
- Backpressure with rf_ready=0. Accept (rd=1, 0xA1), then (rd=2, 0xB2) -> in_ready=0 after the second accept and rf_waddr=1 held. Raise rf_ready -> 0xA1 commits, then 0xB2; in_ready=1 once count=1.
- Forwarding with rf_ready=0. Buffer (rd=3, 0x10), then (rd=3, 0x20); query fwd_raddr=3 -> fwd_hit=1, fwd_data=0x20. Query 4 -> fwd_hit=0, fwd_data=0.
- Discards: accept in_we=0, then rd=0 with in_we=1 (ZERO_REG=1) -> rf_we stays 0 and commit_cnt unchanged. Query fwd_raddr=0 -> fwd_hit=0.
- Out-of-range select with NSRC=3, SELW=2, sel=3 -> data equals src2. Separately, with commit_cnt at 0xFFFF, one commit -> commit_cnt=0x0000.
- Reset mid-operation: with 2 entries pending, assert rst for 1 cycle -> next cycle rf_we=0 and fwd_hit=0, commit_cnt=0 and in_ready=1, and no write of the flushed entries ever appears.
